// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters,
// zero-latency lookup from the IF-stage PC, training from the resolving stage,
// plus saturating branch/mispredict statistics.
module branch_predictor #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned STATSIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [WORDSIZE-1:0] lookup_pc,
    output logic                predict_taken,
    output logic [WORDSIZE-1:0] predict_target,
    input  logic                update_valid,
    input  logic [WORDSIZE-1:0] update_pc,
    input  logic                update_taken,
    input  logic [WORDSIZE-1:0] update_target,
    input  logic                update_predtaken,
    input  logic [WORDSIZE-1:0] update_predtarget,
    output logic                mispredict,
    output logic [STATSIZE-1:0] stat_branches,
    output logic [STATSIZE-1:0] stat_mispredicts
);

    localparam int unsigned INDEXBITS = $clog2(ENTRIES);
    localparam int unsigned TAGBITS   = WORDSIZE - INDEXBITS - 2;

    typedef struct packed {
        logic                valid;
        logic [TAGBITS-1:0]  tag;
        logic [WORDSIZE-1:0] target;
        logic [1:0]          ctr;
    } entry_t;

    entry_t entries_q [ENTRIES];

    logic [INDEXBITS-1:0] lk_idx;
    logic [TAGBITS-1:0]   lk_tag;
    entry_t               lk_entry;
    logic                 lk_hit;

    logic [INDEXBITS-1:0] upd_idx;
    logic [TAGBITS-1:0]   upd_tag;
    entry_t               upd_entry;
    logic                 upd_hit;
    logic                 wr_en;
    entry_t               wr_entry;

    // Byte-offset bits of the PCs never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lk_idx    = lookup_pc[INDEXBITS+1:2];
    assign lk_tag    = lookup_pc[WORDSIZE-1:INDEXBITS+2];
    assign lk_entry  = entries_q[lk_idx];
    assign upd_idx   = update_pc[INDEXBITS+1:2];
    assign upd_tag   = update_pc[WORDSIZE-1:INDEXBITS+2];
    assign upd_entry = entries_q[upd_idx];

    // Lookup reads pre-update state; strongly/weakly taken hits redirect fetch.
    always_comb begin
        lk_hit         = lk_entry.valid && (lk_entry.tag == lk_tag);
        predict_taken  = 1'b0;
        predict_target = lookup_pc + WORDSIZE'(4);
        if (lk_hit && lk_entry.ctr[1]) begin
            predict_taken  = 1'b1;
            predict_target = lk_entry.target;
        end
    end

    // Wrong direction, or taken to a different target than was predicted.
    always_comb begin
        mispredict = 1'b0;
        if (update_valid) begin
            mispredict = (update_taken != update_predtaken) ||
                         (update_taken && (update_predtarget != update_target));
        end
    end

    // Next value of the trained entry; clear drops any concurrent update.
    always_comb begin
        upd_hit  = upd_entry.valid && (upd_entry.tag == upd_tag);
        wr_en    = 1'b0;
        wr_entry = upd_entry;
        if (update_valid && !clear) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (update_taken) begin
                    wr_entry.target = update_target;
                    if (upd_entry.ctr != 2'b11) begin
                        wr_entry.ctr = upd_entry.ctr + 2'(1);
                    end
                end else if (upd_entry.ctr != 2'b00) begin
                    wr_entry.ctr = upd_entry.ctr - 2'(1);
                end
            end else if (update_taken) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = upd_tag;
                wr_entry.target = update_target;
                wr_entry.ctr    = 2'b10;
            end
        end
    end

    // BTB storage: async reset, synchronous invalidate, single write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entries_q[i].valid <= 1'b0;
                entries_q[i].ctr   <= 2'b01;
            end
        end else if (wr_en) begin
            entries_q[upd_idx] <= wr_entry;
        end
    end

    // Saturating performance counters; clear does not suppress counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (update_valid) begin
            if (stat_branches != '1) begin
                stat_branches <= stat_branches + STATSIZE'(1);
            end
            if (mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + STATSIZE'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: behavioural BTB model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [63:0] lookup_pc = '0;
    logic        predict_taken;
    logic [63:0] predict_target;
    logic        update_valid = 1'b0;
    logic [63:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [63:0] update_target = '0;
    logic        update_predtaken = 1'b0;
    logic [63:0] update_predtarget = '0;
    logic        mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    logic        s_predict_taken;
    logic [63:0] s_predict_target;
    logic        s_mispredict;
    logic [3:0]  s_stat_branches;
    logic [3:0]  s_stat_mispredicts;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    branch_predictor #(.WORDSIZE(64), .ENTRIES(16), .STATSIZE(32)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .lookup_pc(lookup_pc),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .update_predtaken(update_predtaken), .update_predtarget(update_predtarget),
        .mispredict(mispredict), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    branch_predictor #(.WORDSIZE(64), .ENTRIES(16), .STATSIZE(4)) u_sat (
        .clk(clk), .rst(rst), .clear(clear), .lookup_pc(lookup_pc),
        .predict_taken(s_predict_taken), .predict_target(s_predict_target),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .update_predtaken(update_predtaken), .update_predtarget(update_predtarget),
        .mispredict(s_mispredict), .stat_branches(s_stat_branches),
        .stat_mispredicts(s_stat_mispredicts)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit              m_valid [16];
    longint unsigned m_tag   [16];
    logic [63:0]     m_tgt   [16];
    int              m_ctr   [16];
    longint          m_br;
    longint          m_mp;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_br = 0;
        m_mp = 0;
    endfunction

    function automatic bit model_hit(input logic [63:0] pc);
        int i;
        i = int'(pc[5:2]);
        return m_valid[i] && (m_tag[i] == longint'(pc >> 6));
    endfunction

    function automatic bit exp_taken(input logic [63:0] pc);
        return model_hit(pc) && (m_ctr[int'(pc[5:2])] >= 2);
    endfunction

    function automatic logic [63:0] exp_target(input logic [63:0] pc);
        if (exp_taken(pc)) return m_tgt[int'(pc[5:2])];
        return pc + 64'd4;
    endfunction

    function automatic bit exp_misp();
        if (!update_valid) return 1'b0;
        return (update_taken != update_predtaken) ||
               (update_taken && (update_predtarget != update_target));
    endfunction

    function automatic logic [63:0] sat(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return 64'((v > lim) ? lim : v);
    endfunction

    // Model state advance on the same edge the DUT trains.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset();
        end else begin
            int  i;
            if (update_valid) begin
                m_br = m_br + 1;
                if (exp_misp()) m_mp = m_mp + 1;
            end
            if (clear) begin
                for (int k = 0; k < 16; k++) begin
                    m_valid[k] = 1'b0;
                    m_ctr[k]   = 1;
                end
            end else if (update_valid) begin
                i = int'(update_pc[5:2]);
                if (model_hit(update_pc)) begin
                    if (update_taken) begin
                        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = update_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (update_taken) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = longint'(update_pc >> 6);
                    m_tgt[i]   = update_target;
                    m_ctr[i]   = 2;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_predict_taken",  64'(predict_taken),      64'(exp_taken(lookup_pc)));
            chk("m_predict_target", predict_target,          exp_target(lookup_pc));
            chk("m_mispredict",     64'(mispredict),         64'(exp_misp()));
            chk("m_stat_branches",  64'(stat_branches),      sat(m_br, 32));
            chk("m_stat_mispred",   64'(stat_mispredicts),   sat(m_mp, 32));
            chk("m_sat_target",     s_predict_target,        exp_target(lookup_pc));
            chk("m_sat_branches",   64'(s_stat_branches),    sat(m_br, 4));
            chk("m_sat_mispred",    64'(s_stat_mispredicts), sat(m_mp, 4));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic upd(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                       input logic ptk, input logic [63:0] ptgt);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_taken      = tk;
        update_target     = tgt;
        update_predtaken  = ptk;
        update_predtarget = ptgt;
    endtask

    task automatic idle();
        update_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic look(input string name, input logic [63:0] pc,
                        input logic tk, input logic [63:0] tgt);
        lookup_pc = pc;
        settle();
        chk({name, "_taken"},  64'(predict_taken), 64'(tk));
        chk({name, "_target"}, predict_target,     tgt);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #1 check_en = 1'b1;
        lookup_pc = 64'h40;
        tick(); tick();
        rst = 1'b1;
        look("rst_lookup", 64'h40, 1'b0, 64'h44);
        chk("rst_branches", 64'(stat_branches),    64'd0);
        chk("rst_mispred",  64'(stat_mispredicts), 64'd0);

        // First taken update allocates, predicted weakly taken.
        upd(64'h40, 1'b1, 64'h100, 1'b0, 64'h0);
        settle();
        chk("alloc_mispredict", 64'(mispredict), 64'd1);
        tick(); idle();
        look("alloc_lookup", 64'h40, 1'b1, 64'h100);
        chk("alloc_branches", 64'(stat_branches),    64'd1);
        chk("alloc_mispred",  64'(stat_mispredicts), 64'd1);

        // Not taken drops to weakly not-taken.
        upd(64'h40, 1'b0, 64'h0, 1'b1, 64'h100);
        tick(); idle();
        look("dec_lookup", 64'h40, 1'b0, 64'h44);

        // Three taken -> 11, then one not taken -> 10.
        for (int k = 0; k < 3; k++) begin
            upd(64'h40, 1'b1, 64'h100, 1'b1, 64'h100);
            tick();
        end
        upd(64'h40, 1'b0, 64'h0, 1'b1, 64'h100);
        tick(); idle();
        look("hyst_lookup", 64'h40, 1'b1, 64'h100);
        chk("hyst_branches", 64'(stat_branches),    64'd6);
        chk("hyst_mispred",  64'(stat_mispredicts), 64'd3);

        // Aliasing on index 0.
        look("alias_miss", 64'h80, 1'b0, 64'h84);
        upd(64'h80, 1'b1, 64'h200, 1'b0, 64'h0);
        tick(); idle();
        look("alias_new", 64'h80, 1'b1, 64'h200);
        look("alias_old", 64'h40, 1'b0, 64'h44);
        upd(64'h400, 1'b0, 64'h0, 1'b0, 64'h0);
        tick(); idle();
        look("noalloc_400", 64'h400, 1'b0, 64'h404);
        look("noalloc_80",  64'h80,  1'b1, 64'h200);

        // Same-cycle lookup sees old state.
        lookup_pc = 64'h40;
        upd(64'h40, 1'b1, 64'h300, 1'b0, 64'h0);
        look("same_old", 64'h40, 1'b0, 64'h44);
        tick(); idle();
        look("same_new", 64'h40, 1'b1, 64'h300);
        chk("same_branches", 64'(stat_branches), 64'd9);

        // Clear wins over a concurrent update, which is still counted.
        clear = 1'b1;
        upd(64'h80, 1'b1, 64'h500, 1'b0, 64'h0);
        tick(); idle();
        look("clear_40", 64'h40, 1'b0, 64'h44);
        look("clear_80", 64'h80, 1'b0, 64'h84);
        chk("clear_branches", 64'(stat_branches),    64'd10);
        chk("clear_mispred",  64'(stat_mispredicts), 64'd6);

        // 20 mispredicted updates saturate the 4-bit counters.
        for (int k = 0; k < 20; k++) begin
            upd(64'h10, 1'b1, 64'h600, 1'b0, 64'h0);
            tick();
        end
        idle();
        look("satur_lookup", 64'h10, 1'b1, 64'h600);
        chk("satur_branches", 64'(s_stat_branches),    64'd15);
        chk("satur_mispred",  64'(s_stat_mispredicts), 64'd15);
        chk("wide_branches",  64'(stat_branches),      64'd30);
        chk("wide_mispred",   64'(stat_mispredicts),   64'd26);

        // Asynchronous reset between edges, with an update in flight.
        tick();
        upd(64'h10, 1'b0, 64'h0, 1'b1, 64'h600);
        lookup_pc = 64'h10;
        settle();
        rst = 1'b0;
        #1;
        chk("arst_taken",    64'(predict_taken),      64'd0);
        chk("arst_target",   predict_target,          64'h14);
        chk("arst_branches", 64'(stat_branches),      64'd0);
        chk("arst_sat_br",   64'(s_stat_branches),    64'd0);
        chk("arst_sat_mp",   64'(s_stat_mispredicts), 64'd0);
        tick();
        rst = 1'b1;
        idle();
        look("post_rst", 64'h10, 1'b0, 64'h14);
        chk("post_rst_branches", 64'(stat_branches), 64'd0);
        tick(); tick();
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
